// File: rtl/lenet_pkg.sv
// rtl/lenet_pkg.sv - shared sizing helpers for the LeNet streaming datapath
package lenet_pkg;

    localparam int DATA_WIDTH_DEF = 32;

    // Output-map side length for a square IFM with kernel k and stride s.
    function automatic int ifm_size_next(input int size, input int k, input int s);
        return (size - k) / s + 1;
    endfunction

    // Shift register length needed to hold K full rows minus the unused tail.
    function automatic int buf_depth(input int size, input int k);
        return (k - 1) * size + k;
    endfunction

    // Shift register tap holding window element (r,c); r=0/c=0 is top-left.
    function automatic int idx(input int r, input int c, input int size, input int k);
        return (k - 1 - r) * size + (k - 1 - c);
    endfunction

    // Counter width that never collapses to zero bits.
    function automatic int clog2_min1(input int v);
        return ($clog2(v) > 0) ? $clog2(v) : 1;
    endfunction

endpackage

// File: rtl/window_max_tree.sv
// rtl/window_max_tree.sv - signed maximum of a packed KxK window, ties to lower index
module window_max_tree #(
    parameter int DATA_WIDTH = 32,
    parameter int NUM_EL     = 4
) (
    input  logic [NUM_EL*DATA_WIDTH-1:0] din,
    output logic [DATA_WIDTH-1:0]        max_out
);

    localparam int LEAVES = 1 << $clog2(NUM_EL);
    localparam int NODES  = 2 * LEAVES - 1;

    // Heap-ordered comparator tree; the left child holds lower indices, so ties keep it.
    always_comb begin : tree
        logic signed [DATA_WIDTH-1:0] val [NODES];
        logic                         vld [NODES];
        for (int n = 0; n < NODES; n++) begin
            val[n] = '0;
            vld[n] = 1'b0;
        end
        for (int i = 0; i < NUM_EL; i++) begin
            val[LEAVES-1+i] = din[i*DATA_WIDTH +: DATA_WIDTH];
            vld[LEAVES-1+i] = 1'b1;
        end
        for (int n = LEAVES - 2; n >= 0; n--) begin
            if (vld[2*n+1] && (!vld[2*n+2] || val[2*n+1] >= val[2*n+2])) begin
                val[n] = val[2*n+1];
                vld[n] = 1'b1;
            end else begin
                val[n] = val[2*n+2];
                vld[n] = vld[2*n+2];
            end
        end
        max_out = val[0];
    end

endmodule

// File: rtl/pool_window_stream_buffer.sv
// rtl/pool_window_stream_buffer.sv - raster pixel stream to aligned KxK windows (optional POOL_MAX_EN max output)
module pool_window_stream_buffer
    import lenet_pkg::*;
#(
    parameter int DATA_WIDTH    = DATA_WIDTH_DEF,
    parameter int IFM_SIZE      = 14,
    parameter int IFM_DEPTH     = 3,
    parameter int KERNEL_SIZE   = 2,
    parameter int STRIDE        = 2,
    parameter int IFM_SIZE_NEXT = ifm_size_next(IFM_SIZE, KERNEL_SIZE, STRIDE),
    parameter int BUF_DEPTH     = buf_depth(IFM_SIZE, KERNEL_SIZE),
    localparam int OW           = clog2_min1(IFM_SIZE_NEXT),
    localparam int CW           = clog2_min1(IFM_DEPTH)
) (
    input  logic                                      clk,
    input  logic                                      reset,
    input  logic                                      in_valid,
    output logic                                      in_ready,
    input  logic [DATA_WIDTH-1:0]                     in_data,
    output logic                                      out_valid,
    input  logic                                      out_ready,
    output logic [KERNEL_SIZE*KERNEL_SIZE*DATA_WIDTH-1:0] win_data,
    output logic [OW-1:0]                             out_row,
    output logic [OW-1:0]                             out_col,
    output logic [CW-1:0]                             out_chan,
    output logic                                      frame_done
`ifdef POOL_MAX_EN
    ,
    output logic [DATA_WIDTH-1:0]                     max_out
`endif
);

    localparam int PW = clog2_min1(IFM_SIZE);
    localparam int SW = clog2_min1(STRIDE);
    localparam logic [PW-1:0] K_M1     = PW'(KERNEL_SIZE - 1);
    localparam logic [PW-1:0] POS_LAST = PW'(IFM_SIZE - 1);
    localparam logic [SW-1:0] S_LAST   = SW'(STRIDE - 1);
    localparam logic [OW-1:0] N_LAST   = OW'(IFM_SIZE_NEXT - 1);
    localparam logic [CW-1:0] D_LAST   = CW'(IFM_DEPTH - 1);

    logic [DATA_WIDTH-1:0] buf_q [BUF_DEPTH];
    logic [DATA_WIDTH-1:0] buf_d [BUF_DEPTH];
    logic [PW-1:0] col_q, col_d, row_q, row_d;
    logic [SW-1:0] cph_q, cph_d, rph_q, rph_d;
    logic [CW-1:0] chan_q, chan_d, out_chan_q, out_chan_d;
    logic [OW-1:0] wcol_q, wcol_d, wrow_q, wrow_d;
    logic [OW-1:0] out_row_q, out_row_d, out_col_q, out_col_d;
    logic out_valid_q, out_valid_d, out_last_q, out_last_d;
    logic frame_done_q, frame_done_d;
    logic accept, complete, col_wrap, row_wrap;

    assign in_ready   = !out_valid_q || out_ready;
    assign out_valid  = out_valid_q;
    assign out_row    = out_row_q;
    assign out_col    = out_col_q;
    assign out_chan   = out_chan_q;
    assign frame_done = frame_done_q;

    // Window taps read straight from the shift register, which is frozen while a window waits.
    for (genvar r = 0; r < KERNEL_SIZE; r++) begin : g_row
        for (genvar c = 0; c < KERNEL_SIZE; c++) begin : g_col
            assign win_data[(r*KERNEL_SIZE+c)*DATA_WIDTH +: DATA_WIDTH] =
                buf_q[idx(r, c, IFM_SIZE, KERNEL_SIZE)];
        end
    end

    // Next-state: shift on accept, raster/stride counters, window detection and output handshake.
    always_comb begin
        accept   = in_valid && in_ready;
        col_wrap = (col_q == POS_LAST);
        row_wrap = (row_q == POS_LAST);
        complete = accept && (row_q >= K_M1) && (col_q >= K_M1) && (rph_q == '0) && (cph_q == '0);

        buf_d        = buf_q;
        col_d        = col_q;
        row_d        = row_q;
        cph_d        = cph_q;
        rph_d        = rph_q;
        chan_d       = chan_q;
        wcol_d       = wcol_q;
        wrow_d       = wrow_q;
        out_valid_d  = out_valid_q;
        out_last_d   = out_last_q;
        out_row_d    = out_row_q;
        out_col_d    = out_col_q;
        out_chan_d   = out_chan_q;
        frame_done_d = out_valid_q && out_ready && out_last_q;

        if (accept) begin
            buf_d[0] = in_data;
            for (int i = 1; i < BUF_DEPTH; i++) begin
                buf_d[i] = buf_q[i-1];
            end
            // Phase counters only run once the window fits, and restart at every wrap.
            col_d = col_wrap ? '0 : col_q + 1'b1;
            if (col_wrap || col_q < K_M1) cph_d = '0;
            else                          cph_d = (cph_q == S_LAST) ? '0 : cph_q + 1'b1;
            if (col_wrap) begin
                row_d = row_wrap ? '0 : row_q + 1'b1;
                if (row_wrap || row_q < K_M1) rph_d = '0;
                else                          rph_d = (rph_q == S_LAST) ? '0 : rph_q + 1'b1;
                if (row_wrap) chan_d = (chan_q == D_LAST) ? '0 : chan_q + 1'b1;
            end
        end

        if (complete) begin
            out_valid_d = 1'b1;
            out_row_d   = wrow_q;
            out_col_d   = wcol_q;
            out_chan_d  = chan_q;
            out_last_d  = (chan_q == D_LAST) && (wrow_q == N_LAST) && (wcol_q == N_LAST);
            wcol_d      = (wcol_q == N_LAST) ? '0 : wcol_q + 1'b1;
            if (wcol_q == N_LAST) wrow_d = (wrow_q == N_LAST) ? '0 : wrow_q + 1'b1;
        end else if (out_ready) begin
            out_valid_d = 1'b0;
        end
    end

    // State registers with asynchronous clear.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < BUF_DEPTH; i++) buf_q[i] <= '0;
            col_q        <= '0;
            row_q        <= '0;
            cph_q        <= '0;
            rph_q        <= '0;
            chan_q       <= '0;
            wcol_q       <= '0;
            wrow_q       <= '0;
            out_valid_q  <= 1'b0;
            out_last_q   <= 1'b0;
            out_row_q    <= '0;
            out_col_q    <= '0;
            out_chan_q   <= '0;
            frame_done_q <= 1'b0;
        end else begin
            buf_q        <= buf_d;
            col_q        <= col_d;
            row_q        <= row_d;
            cph_q        <= cph_d;
            rph_q        <= rph_d;
            chan_q       <= chan_d;
            wcol_q       <= wcol_d;
            wrow_q       <= wrow_d;
            out_valid_q  <= out_valid_d;
            out_last_q   <= out_last_d;
            out_row_q    <= out_row_d;
            out_col_q    <= out_col_d;
            out_chan_q   <= out_chan_d;
            frame_done_q <= frame_done_d;
        end
    end

`ifdef POOL_MAX_EN
    window_max_tree #(
        .DATA_WIDTH (DATA_WIDTH),
        .NUM_EL     (KERNEL_SIZE*KERNEL_SIZE)
    ) u_max (
        .din     (win_data),
        .max_out (max_out)
    );
`endif

endmodule
